// File: rtl/axicb_pkg.sv
// Shared types for the crossbar slave-side switch: outstanding-route table entry
// and pointer width helper.
package axicb_pkg;

  localparam int SLV_NB_MAX = 4;

  typedef struct packed {
    logic                  decerr;
    logic [SLV_NB_MAX-1:0] sel;
  } route_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axicb_slv_addr_decode.sv
// Address-range decoder: one-hot slave select (lowest index wins) or decode error,
// filtered by the master's allowed routes. Shared by read and write paths.
module axicb_slv_addr_decode
  import axicb_pkg::*;
#(
  parameter int          AXI_ADDR_W      = 8,
  parameter int          SLV_NB          = 4,
  parameter logic [3:0]  MST_ROUTES      = 4'b1111,
  parameter logic [63:0] SLV0_START_ADDR = 0,
  parameter logic [63:0] SLV0_END_ADDR   = 4095,
  parameter logic [63:0] SLV1_START_ADDR = 4096,
  parameter logic [63:0] SLV1_END_ADDR   = 8191,
  parameter logic [63:0] SLV2_START_ADDR = 8192,
  parameter logic [63:0] SLV2_END_ADDR   = 12287,
  parameter logic [63:0] SLV3_START_ADDR = 12288,
  parameter logic [63:0] SLV3_END_ADDR   = 16383
) (
  input  logic [AXI_ADDR_W-1:0] addr,
  output logic [SLV_NB-1:0]     sel,
  output logic                  decerr
);

  localparam logic [63:0] START [SLV_NB_MAX] =
    '{SLV0_START_ADDR, SLV1_START_ADDR, SLV2_START_ADDR, SLV3_START_ADDR};
  localparam logic [63:0] STOP [SLV_NB_MAX] =
    '{SLV0_END_ADDR, SLV1_END_ADDR, SLV2_END_ADDR, SLV3_END_ADDR};

  logic [63:0] addr_ext;
  logic        found;

  assign addr_ext = 64'(addr);

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < SLV_NB; i++) begin
      if (!found && MST_ROUTES[i] && addr_ext >= START[i] && addr_ext <= STOP[i]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign decerr = (sel == '0);

endmodule

// File: rtl/axicb_slv_wr_route_ctrl.sv
// Write-path route scheduler for one master port: queues decoded AW routes,
// steers W bursts then B responses in AW order, throttles AW when the table is full.
module axicb_slv_wr_route_ctrl
  import axicb_pkg::*;
#(
  parameter int          AXI_ADDR_W      = 8,
  parameter int          SLV_NB          = 4,
  parameter logic [3:0]  MST_ROUTES      = 4'b1111,
  parameter int          MST_OSTDREQ_NUM = 4,
  parameter logic [63:0] SLV0_START_ADDR = 0,
  parameter logic [63:0] SLV0_END_ADDR   = 4095,
  parameter logic [63:0] SLV1_START_ADDR = 4096,
  parameter logic [63:0] SLV1_END_ADDR   = 8191,
  parameter logic [63:0] SLV2_START_ADDR = 8192,
  parameter logic [63:0] SLV2_END_ADDR   = 12287,
  parameter logic [63:0] SLV3_START_ADDR = 12288,
  parameter logic [63:0] SLV3_END_ADDR   = 16383
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic [AXI_ADDR_W-1:0] i_awaddr,
  input  logic                  i_aw_fire,
  output logic [SLV_NB-1:0]     o_aw_sel,
  output logic                  o_aw_decerr,
  output logic                  o_aw_stall,
  input  logic                  i_w_fire,
  input  logic                  i_wlast,
  output logic                  o_w_en,
  output logic [SLV_NB-1:0]     o_w_sel,
  output logic                  o_w_sink,
  input  logic                  i_b_fire,
  output logic                  o_b_en,
  output logic [SLV_NB-1:0]     o_b_sel,
  output logic                  o_b_decerr
);

  localparam int PW = ptr_w(MST_OSTDREQ_NUM);
  localparam int CW = PW + 1;

  // Handshake contract: each *_fire input is a completed valid&ready transfer on the
  // switch side, and is legal only while the matching enable (or !o_aw_stall) is high.

  route_t          table_q [MST_OSTDREQ_NUM];
  route_t          aw_entry;
  logic [PW-1:0]   wr_ptr, w_ptr, b_ptr;
  logic [CW-1:0]   w_cnt, b_cnt, w_cnt_nxt, b_cnt_nxt;
  logic            aw_push, w_done, b_pop;

  axicb_slv_addr_decode #(
    .AXI_ADDR_W(AXI_ADDR_W), .SLV_NB(SLV_NB), .MST_ROUTES(MST_ROUTES),
    .SLV0_START_ADDR(SLV0_START_ADDR), .SLV0_END_ADDR(SLV0_END_ADDR),
    .SLV1_START_ADDR(SLV1_START_ADDR), .SLV1_END_ADDR(SLV1_END_ADDR),
    .SLV2_START_ADDR(SLV2_START_ADDR), .SLV2_END_ADDR(SLV2_END_ADDR),
    .SLV3_START_ADDR(SLV3_START_ADDR), .SLV3_END_ADDR(SLV3_END_ADDR)
  ) u_decode (
    .addr   (i_awaddr),
    .sel    (o_aw_sel),
    .decerr (o_aw_decerr)
  );

  assign o_aw_stall = ((w_cnt + b_cnt) == CW'(MST_OSTDREQ_NUM));
  assign aw_push    = i_aw_fire && !o_aw_stall;
  assign o_w_en     = (w_cnt != '0);
  assign o_b_en     = (b_cnt != '0);
  assign w_done     = i_w_fire && i_wlast && o_w_en;
  assign b_pop      = i_b_fire && o_b_en;
  assign aw_entry   = '{decerr: o_aw_decerr, sel: SLV_NB_MAX'(o_aw_sel)};

  assign o_w_sel    = o_w_en ? table_q[w_ptr].sel[SLV_NB-1:0] : '0;
  assign o_w_sink   = o_w_en && table_q[w_ptr].decerr;
  assign o_b_sel    = o_b_en ? table_q[b_ptr].sel[SLV_NB-1:0] : '0;
  assign o_b_decerr = o_b_en && table_q[b_ptr].decerr;

  // A completing W burst moves its entry from the W count to the B count.
  always_comb begin
    w_cnt_nxt = w_cnt;
    b_cnt_nxt = b_cnt;
    if (aw_push) w_cnt_nxt = w_cnt_nxt + CW'(1);
    if (w_done) begin
      w_cnt_nxt = w_cnt_nxt - CW'(1);
      b_cnt_nxt = b_cnt_nxt + CW'(1);
    end
    if (b_pop) b_cnt_nxt = b_cnt_nxt - CW'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      w_ptr  <= '0;
      b_ptr  <= '0;
      w_cnt  <= '0;
      b_cnt  <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      w_ptr  <= '0;
      b_ptr  <= '0;
      w_cnt  <= '0;
      b_cnt  <= '0;
    end else begin
      if (aw_push) wr_ptr <= wr_ptr + PW'(1);
      if (w_done)  w_ptr  <= w_ptr + PW'(1);
      if (b_pop)   b_ptr  <= b_ptr + PW'(1);
      w_cnt <= w_cnt_nxt;
      b_cnt <= b_cnt_nxt;
    end
  end

  // Entries are only read while counted valid, so storage needs no reset.
  always_ff @(posedge aclk) begin
    if (aw_push) table_q[wr_ptr] <= aw_entry;
  end

  a_aw_no_stall: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    i_aw_fire |-> !o_aw_stall) else $error("aw_fire while table full");
  a_w_en: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    i_w_fire |-> o_w_en) else $error("w_fire with no W route");
  a_b_en: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    i_b_fire |-> o_b_en) else $error("b_fire with no B route");

endmodule
